// File: rtl/spi_regbank_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_regbank_slave: oversampled SPI mode-0 slave with status/ctrl bank       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_regbank_slave #(
  parameter int                      ST_BYTES   = 2,
  parameter int                      CTRL_BYTES = 2,
  parameter logic [CTRL_BYTES*8-1:0] CTRL_RESET = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  input  logic [ST_BYTES*8-1:0]   status,
  output logic [CTRL_BYTES*8-1:0] ctrl,
  output logic                    wr_pulse,
  output logic [15:0]             wr_addr,
  output logic                    frame_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_DATA = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [7:0] C_INST_RD_ST   = 8'h03;
  localparam logic [7:0] C_INST_RD_CTRL = 8'h0B;
  localparam logic [7:0] C_INST_WR_CTRL = 8'h02;

  logic r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic r_cs_s1,   r_cs_s2,   r_cs_h;
  logic r_mosi_s1, r_mosi_s2, r_mosi_h;

  state_t      r_state, w_nxt;
  logic [22:0] r_hdr;
  logic [4:0]  r_bitcnt;
  logic [2:0]  r_dcnt;
  logic [15:0] r_addr;
  logic [7:0]  r_inst;
  logic [7:0]  r_sh;

  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic [23:0] w_hdr_nxt;
  logic        w_hdr_done;
  logic [7:0]  w_rd_inst;
  logic [15:0] w_rd_addr;
  logic [7:0]  w_rd_byte;
  logic [7:0]  w_wr_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_h <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_h   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0; r_mosi_h <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_h <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n; r_cs_s2   <= r_cs_s1;   r_cs_h   <= r_cs_s2;
      r_mosi_s1 <= spi_mosi; r_mosi_s2 <= r_mosi_s1; r_mosi_h <= r_mosi_s2;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_h;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_h;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_h;
  // mosi sampled one clk ahead of the detected rise, where mode-0 data is settled
  assign w_hdr_nxt   = {r_hdr, r_mosi_h};
  assign w_wr_byte   = {r_sh[6:0], r_mosi_h};
  assign w_hdr_done  = w_sclk_rise && (r_bitcnt == 5'd23);

  assign w_rd_inst = (r_state == S_HEADER) ? w_hdr_nxt[23:16] : r_inst;
  assign w_rd_addr = (r_state == S_HEADER) ? w_hdr_nxt[15:0]  : r_addr + 16'd1;

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_rd_inst == C_INST_RD_ST) begin
      for (int i = 0; i < ST_BYTES; i++)
        if (w_rd_addr == 16'(i)) w_rd_byte = status[i*8 +: 8];
    end else begin
      for (int i = 0; i < CTRL_BYTES; i++)
        if (w_rd_addr == 16'(i)) w_rd_byte = ctrl[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (w_cs_rise) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_cs_fall) w_nxt = S_HEADER;
        S_HEADER: if (w_hdr_done) begin
          case (w_hdr_nxt[23:16])
            C_INST_RD_ST, C_INST_RD_CTRL: w_nxt = S_RD_DATA;
            C_INST_WR_CTRL:               w_nxt = S_WR_DATA;
            default:                      w_nxt = S_DISCARD;
          endcase
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr       <= '0;
      r_bitcnt    <= '0;
      r_dcnt      <= '0;
      r_addr      <= '0;
      r_inst      <= '0;
      r_sh        <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      ctrl        <= CTRL_RESET;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (w_cs_rise) begin
        // cs release wins over any same-clk sclk edge, so a completing byte is dropped
        if ((r_state == S_HEADER) ||
            (((r_state == S_RD_DATA) || (r_state == S_WR_DATA)) && (r_dcnt != 3'd0)))
          frame_err <= 1'b1;
        r_hdr       <= '0;
        r_bitcnt    <= '0;
        r_dcnt      <= '0;
        r_addr      <= '0;
        r_inst      <= '0;
        r_sh        <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_bitcnt <= '0;
            r_dcnt   <= '0;
            r_hdr    <= '0;
          end
          S_HEADER: if (w_sclk_rise) begin
            r_hdr    <= w_hdr_nxt[22:0];
            r_bitcnt <= r_bitcnt + 5'd1;
            if (w_hdr_done) begin
              r_inst <= w_hdr_nxt[23:16];
              r_addr <= w_hdr_nxt[15:0];
              r_dcnt <= '0;
              if ((w_hdr_nxt[23:16] == C_INST_RD_ST) || (w_hdr_nxt[23:16] == C_INST_RD_CTRL)) begin
                r_sh        <= w_rd_byte;
                spi_miso_oe <= 1'b1;
              end
            end
          end
          S_RD_DATA: begin
            if (w_sclk_fall) begin
              spi_miso <= r_sh[7];
              r_sh     <= {r_sh[6:0], 1'b0};
            end
            if (w_sclk_rise) begin
              r_dcnt <= r_dcnt + 3'd1;
              if (r_dcnt == 3'd7) begin
                r_addr <= r_addr + 16'd1;
                r_sh   <= w_rd_byte;
              end
            end
          end
          S_WR_DATA: if (w_sclk_rise) begin
            r_sh   <= w_wr_byte;
            r_dcnt <= r_dcnt + 3'd1;
            if (r_dcnt == 3'd7) begin
              r_addr <= r_addr + 16'd1;
              for (int i = 0; i < CTRL_BYTES; i++) begin
                if (r_addr == 16'(i)) begin
                  ctrl[i*8 +: 8] <= w_wr_byte;
                  wr_pulse       <= 1'b1;
                  wr_addr        <= r_addr;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_regbank_slave: directed SPI frames against spi_regbank_slave         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_regbank_slave;

  localparam logic [15:0] C_CTRL_RST = 16'hC35A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [15:0] status = 16'h0000;
  logic [15:0] ctrl;
  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_ferr = 0;
  logic [15:0] pulse_log [0:15];

  int          tog_on = -1;
  int          tog_off = -1;
  logic [15:0] st_alt = 16'h0000;
  logic [15:0] st_orig = 16'h0000;

  logic [63:0] rx, oev;

  spi_regbank_slave #(
    .ST_BYTES  (2),
    .CTRL_BYTES(2),
    .CTRL_RESET(C_CTRL_RST)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .status     (status),
    .ctrl       (ctrl),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) begin
      if (n_pulse < 16) pulse_log[n_pulse] = wr_addr;
      n_pulse = n_pulse + 1;
    end
    if (frame_err) n_ferr = n_ferr + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_end();
    #40;
    spi_cs_n = 1'b1;
    #80;
  endtask

  // sclk = clk/8; master samples miso/oe just before each rise
  task automatic xfer(input logic [63:0] tx, input int n, output logic [63:0] r, output logic [63:0] o);
    r = '0;
    o = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if ((n - 1 - i) == tog_on)  status = st_alt;
      if ((n - 1 - i) == tog_off) status = st_orig;
      spi_mosi = tx[i];
      #40;
      r = {r[62:0], spi_miso};
      o = {o[62:0], spi_miso_oe};
      spi_sclk = 1'b1;
      #40;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] tx, input int n, output logic [63:0] r, output logic [63:0] o);
    cs_begin();
    xfer(tx, n, r, o);
    cs_end();
  endtask

  initial begin
    #23;
    @(negedge clk);
    reset_n = 1'b1;
    #40;

    chk_eq("rst_miso",  64'(spi_miso),    64'h0);
    chk_eq("rst_oe",    64'(spi_miso_oe), 64'h0);
    chk_eq("rst_ctrl",  64'(ctrl),        64'(C_CTRL_RST));
    chk_eq("rst_pulse", 64'(wr_pulse),    64'h0);
    chk_eq("rst_waddr", 64'(wr_addr),     64'h0);
    chk_eq("rst_ferr",  64'(frame_err),   64'h0);

    // single read of status byte 1
    status = 16'h0300;
    frame(64'h03000100, 32, rx, oev);
    chk_eq("rd1_byte", 64'(rx[7:0]),  64'h03);
    chk_eq("rd1_oe",   64'(oev[31:0]), 64'h0000_00FF);
    chk_eq("rd1_ferr", 64'(n_ferr),    64'h0);
    chk_eq("rd1_oe_idle", 64'(spi_miso_oe), 64'h0);

    // burst read; status disturbed mid first byte must not leak in
    status  = 16'h8003;
    st_orig = 16'h8003;
    st_alt  = 16'h7FFC;
    tog_on  = 26;
    tog_off = 30;
    frame(64'h030000_000000, 48, rx, oev);
    tog_on  = -1;
    tog_off = -1;
    chk_eq("burst_bytes", 64'(rx[23:0]),  64'h03_80_00);
    chk_eq("burst_oe",    64'(oev[47:0]), 64'h0000_00FF_FFFF);

    // burst write then ctrl readback
    frame(64'h020000_AA55, 40, rx, oev);
    chk_eq("wr_ctrl",   64'(ctrl),         64'h55AA);
    chk_eq("wr_npulse", 64'(n_pulse),      64'd2);
    chk_eq("wr_addr0",  64'(pulse_log[0]), 64'h0);
    chk_eq("wr_addr1",  64'(pulse_log[1]), 64'h1);
    chk_eq("wr_oe",     64'(oev[39:0]),    64'h0);
    chk_eq("wr_miso",   64'(rx[39:0]),     64'h0);
    frame(64'h0B000100, 32, rx, oev);
    chk_eq("rb_byte1", 64'(rx[7:0]), 64'h55);
    frame(64'h0B000000, 32, rx, oev);
    chk_eq("rb_byte0", 64'(rx[7:0]), 64'hAA);

    // out-of-range write and unknown instruction
    frame(64'h02000512, 32, rx, oev);
    chk_eq("oor_ctrl",   64'(ctrl),    64'h55AA);
    chk_eq("oor_npulse", 64'(n_pulse), 64'd2);
    frame(64'h9F0000_1234, 40, rx, oev);
    chk_eq("unk_miso", 64'(rx[39:0]),  64'h0);
    chk_eq("unk_oe",   64'(oev[39:0]), 64'h0);
    chk_eq("unk_ctrl", 64'(ctrl),      64'h55AA);
    chk_eq("unk_ferr", 64'(n_ferr),    64'h0);

    // aborted write after 4 data bits
    frame(64'h020000F, 28, rx, oev);
    chk_eq("abort_ctrl",   64'(ctrl),    64'h55AA);
    chk_eq("abort_ferr",   64'(n_ferr),  64'd1);
    chk_eq("abort_npulse", 64'(n_pulse), 64'd2);
    status = 16'h5AA5;
    frame(64'h03000100, 32, rx, oev);
    chk_eq("abort_rd", 64'(rx[7:0]), 64'h5A);

    // short header is malformed
    frame(64'h0300, 16, rx, oev);
    chk_eq("short_ferr", 64'(n_ferr), 64'd2);

    // reset in the middle of a write data byte
    cs_begin();
    xfer(64'h020000A, 28, rx, oev);
    reset_n = 1'b0;
    #30;
    chk_eq("mrst_ctrl", 64'(ctrl),        64'(C_CTRL_RST));
    chk_eq("mrst_oe",   64'(spi_miso_oe), 64'h0);
    chk_eq("mrst_miso", 64'(spi_miso),    64'h0);
    spi_cs_n = 1'b1;
    #50;
    reset_n = 1'b1;
    #50;
    frame(64'h0200017E, 32, rx, oev);
    chk_eq("post_ctrl",   64'(ctrl),         64'h7E5A);
    chk_eq("post_npulse", 64'(n_pulse),      64'd3);
    chk_eq("post_waddr",  64'(pulse_log[2]), 64'h1);
    chk_eq("post_ferr",   64'(n_ferr),       64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
